// File: rtl/connect_n_game_fsm.sv
// connect_n_game_fsm: Connect-N game-flow controller. Sequences new game,
// cursor moves, drop, drop sound, win/draw check and turn hand-off.
// Ports:
//   CLOCK_50, reset      clock, synchronous active-high reset
//   bt                   key code: 00 none, 01 right, 10 left, 11 select
//   col_full             per-column full flags from the board
//   done_drop_piece      datapath finished placing the piece
//   done_check_winner    winner result valid; winner = line completed
//   turn, col            current player and cursor column
//   game_state           0 start, 1 playing, 2 win, 3 draw
//   drop_a_piece         1-cycle drop command
//   check_for_winner     1-cycle win-check command
//   reset_ps2            1-cycle key decoder latch clear
//   sound_en             drop sound enable
//   rejected             1-cycle pulse: drop into a full column
//   move_count           pieces placed this game
// All outputs are registered.
module connect_n_game_fsm #(
  parameter int NUM_COLS     = 7,
  parameter int NUM_ROWS     = 6,
  parameter int NUM_PLAYERS  = 2,
  parameter int START_COL    = 0,
  parameter int WRAP         = 1,
  parameter int SOUND_CYCLES = 5000000,
  localparam int TW = (NUM_PLAYERS > 2) ?
                      $clog2(NUM_PLAYERS) : 1,
  localparam int CW = (NUM_COLS > 2) ?
                      $clog2(NUM_COLS) : 1,
  localparam int MW = $clog2(NUM_COLS * NUM_ROWS + 1)
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [1:0]          bt,
  input  logic [NUM_COLS-1:0] col_full,
  input  logic                done_drop_piece,
  input  logic                done_check_winner,
  input  logic                winner,
  output logic [TW-1:0]       turn,
  output logic [CW-1:0]       col,
  output logic [1:0]          game_state,
  output logic                drop_a_piece,
  output logic                check_for_winner,
  output logic                reset_ps2,
  output logic                sound_en,
  output logic                rejected,
  output logic [MW-1:0]       move_count
);

  localparam int SW = (SOUND_CYCLES > 1) ?
                      $clog2(SOUND_CYCLES) : 1;

  localparam logic [CW-1:0] FIRST_COL =
    CW'(START_COL);
  localparam logic [CW-1:0] LAST_COL =
    CW'(NUM_COLS - 1);
  localparam logic [TW-1:0] LAST_P =
    TW'(NUM_PLAYERS - 1);
  localparam logic [MW-1:0] ALL_CELLS =
    MW'(NUM_COLS * NUM_ROWS);
  localparam logic [SW-1:0] SND_LAST =
    SW'(SOUND_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START_WAIT,
    S_TURN,
    S_MV_L,
    S_MV_R,
    S_SEL_WAIT,
    S_DROP,
    S_SOUND,
    S_CHECK,
    S_WIN,
    S_DRAW
  } state_t;

  state_t state;
  state_t state_d;

  logic [TW-1:0] turn_d;
  logic [CW-1:0] col_d;
  logic [MW-1:0] moves_d;
  logic [SW-1:0] snd_cnt;
  logic [SW-1:0] snd_cnt_d;
  logic [1:0]    gs_d;
  logic          drop_d;
  logic          check_d;
  logic          ps2_d;
  logic          rej_d;
  logic          sound_d;
  logic          new_game;

  logic key_none;
  logic key_r;
  logic key_l;
  logic key_s;

  assign key_none = (bt == 2'b00);
  assign key_r    = (bt == 2'b01);
  assign key_l    = (bt == 2'b10);
  assign key_s    = (bt == 2'b11);

  always_comb begin
    state_d   = state;
    turn_d    = turn;
    col_d     = col;
    moves_d   = move_count;
    snd_cnt_d = snd_cnt;
    drop_d    = 1'b0;
    check_d   = 1'b0;
    ps2_d     = 1'b0;
    rej_d     = 1'b0;
    new_game  = 1'b0;
    gs_d      = 2'd1;
    sound_d   = 1'b0;

    case (state)
      S_IDLE, S_WIN, S_DRAW: begin
        if (key_s) begin
          state_d  = S_START_WAIT;
          new_game = 1'b1;
        end
      end

      S_START_WAIT: begin
        if (key_none) state_d = S_TURN;
      end

      S_TURN: begin
        unique case (1'b1)
          key_r:   state_d = S_MV_R;
          key_l:   state_d = S_MV_L;
          key_s:   state_d = S_SEL_WAIT;
          default: state_d = S_TURN;
        endcase
      end

      // The step is taken on release, so a held
      // key moves the cursor exactly once.
      S_MV_L: begin
        if (key_none) begin
          state_d = S_TURN;
          ps2_d   = 1'b1;
          if (col != '0)
            col_d = col - 1'b1;
          else if (WRAP != 0)
            col_d = LAST_COL;
          else
            col_d = '0;
        end
      end

      S_MV_R: begin
        if (key_none) begin
          state_d = S_TURN;
          ps2_d   = 1'b1;
          if (col != LAST_COL)
            col_d = col + 1'b1;
          else if (WRAP != 0)
            col_d = '0;
          else
            col_d = LAST_COL;
        end
      end

      S_SEL_WAIT: begin
        if (key_none) begin
          ps2_d = 1'b1;
          if (col_full[col]) begin
            state_d = S_TURN;
            rej_d   = 1'b1;
          end else begin
            state_d = S_DROP;
            drop_d  = 1'b1;
          end
        end
      end

      S_DROP: begin
        if (done_drop_piece) begin
          state_d   = S_SOUND;
          moves_d   = move_count + 1'b1;
          snd_cnt_d = '0;
        end
      end

      S_SOUND: begin
        if (snd_cnt == SND_LAST) begin
          state_d   = S_CHECK;
          check_d   = 1'b1;
          snd_cnt_d = '0;
        end else begin
          snd_cnt_d = snd_cnt + 1'b1;
        end
      end

      // Win is tested before the full-board draw.
      S_CHECK: begin
        if (done_check_winner) begin
          if (winner) begin
            state_d = S_WIN;
          end else if (move_count == ALL_CELLS) begin
            state_d = S_DRAW;
          end else begin
            state_d = S_TURN;
            if (turn == LAST_P)
              turn_d = '0;
            else
              turn_d = turn + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (new_game) begin
      turn_d  = '0;
      col_d   = FIRST_COL;
      moves_d = '0;
      ps2_d   = 1'b1;
    end

    // Outputs are registered, so they follow the
    // state being entered, not the current one.
    case (state_d)
      S_IDLE, S_START_WAIT: gs_d = 2'd0;
      S_WIN:                gs_d = 2'd2;
      S_DRAW:               gs_d = 2'd3;
      default:              gs_d = 2'd1;
    endcase

    sound_d = (state_d == S_SOUND);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state            <= S_IDLE;
      turn             <= '0;
      col              <= FIRST_COL;
      move_count       <= '0;
      snd_cnt          <= '0;
      game_state       <= 2'd0;
      drop_a_piece     <= 1'b0;
      check_for_winner <= 1'b0;
      reset_ps2        <= 1'b0;
      sound_en         <= 1'b0;
      rejected         <= 1'b0;
    end else begin
      state            <= state_d;
      turn             <= turn_d;
      col              <= col_d;
      move_count       <= moves_d;
      snd_cnt          <= snd_cnt_d;
      game_state       <= gs_d;
      drop_a_piece     <= drop_d;
      check_for_winner <= check_d;
      reset_ps2        <= ps2_d;
      sound_en         <= sound_d;
      rejected         <= rej_d;
    end
  end

endmodule

// File: tb/tb_connect_n_game_fsm.sv
// tb_connect_n_game_fsm: three differently parametrised instances
// driven by directed and random play against a game-level model.
module tb_connect_n_game_fsm;

  logic clk;
  logic rst [3];
  logic [1:0] bt [3];
  logic [6:0] cf [3];
  logic dd [3];
  logic dc [3];
  logic wn [3];

  wire [1:0] gs [3];
  wire drp [3];
  wire chkp [3];
  wire rps [3];
  wire snd [3];
  wire rej [3];

  logic [1:0] turn_a;
  logic       turn_b;
  logic       turn_c;
  logic [2:0] col_a;
  logic [2:0] col_b;
  logic       col_c;
  logic [5:0] mc_a;
  logic [5:0] mc_b;
  logic [2:0] mc_c;

  int npass = 0;
  int ntot = 0;

  int n_rps [3];
  int n_drp [3];
  int n_chk [3];
  int n_rej [3];
  int n_snd [3];
  int b_rps [3];
  int b_drp [3];
  int b_chk [3];
  int b_rej [3];
  int b_snd [3];

  int m_phase [3];
  int m_turn [3];
  int m_col [3];
  int m_moves [3];
  int ht [3][7];
  logic [6:0] force_full [3];

  connect_n_game_fsm #(
    .NUM_COLS(7), .NUM_ROWS(6), .NUM_PLAYERS(3),
    .START_COL(0), .WRAP(1), .SOUND_CYCLES(10)
  ) dut_a (
    .CLOCK_50(clk), .reset(rst[0]), .bt(bt[0]),
    .col_full(cf[0]), .done_drop_piece(dd[0]),
    .done_check_winner(dc[0]), .winner(wn[0]),
    .turn(turn_a), .col(col_a), .game_state(gs[0]),
    .drop_a_piece(drp[0]),
    .check_for_winner(chkp[0]),
    .reset_ps2(rps[0]), .sound_en(snd[0]),
    .rejected(rej[0]), .move_count(mc_a)
  );

  connect_n_game_fsm #(
    .NUM_COLS(7), .NUM_ROWS(6), .NUM_PLAYERS(2),
    .START_COL(4), .WRAP(0), .SOUND_CYCLES(3)
  ) dut_b (
    .CLOCK_50(clk), .reset(rst[1]), .bt(bt[1]),
    .col_full(cf[1]), .done_drop_piece(dd[1]),
    .done_check_winner(dc[1]), .winner(wn[1]),
    .turn(turn_b), .col(col_b), .game_state(gs[1]),
    .drop_a_piece(drp[1]),
    .check_for_winner(chkp[1]),
    .reset_ps2(rps[1]), .sound_en(snd[1]),
    .rejected(rej[1]), .move_count(mc_b)
  );

  connect_n_game_fsm #(
    .NUM_COLS(2), .NUM_ROWS(2), .NUM_PLAYERS(2),
    .START_COL(0), .WRAP(1), .SOUND_CYCLES(2)
  ) dut_c (
    .CLOCK_50(clk), .reset(rst[2]), .bt(bt[2]),
    .col_full(cf[2][1:0]), .done_drop_piece(dd[2]),
    .done_check_winner(dc[2]), .winner(wn[2]),
    .turn(turn_c), .col(col_c), .game_state(gs[2]),
    .drop_a_piece(drp[2]),
    .check_for_winner(chkp[2]),
    .reset_ps2(rps[2]), .sound_en(snd[2]),
    .rejected(rej[2]), .move_count(mc_c)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rps[k])  n_rps[k]++;
      if (drp[k])  n_drp[k]++;
      if (chkp[k]) n_chk[k]++;
      if (rej[k])  n_rej[k]++;
      if (snd[k])  n_snd[k]++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int nc(input int k);
    return (k == 2) ? 2 : 7;
  endfunction
  function automatic int nr(input int k);
    return (k == 2) ? 2 : 6;
  endfunction
  function automatic int np(input int k);
    return (k == 0) ? 3 : 2;
  endfunction
  function automatic int wrapf(input int k);
    return (k == 1) ? 0 : 1;
  endfunction
  function automatic int scyc(input int k);
    return (k == 0) ? 10 : ((k == 1) ? 3 : 2);
  endfunction
  function automatic int stc(input int k);
    return (k == 1) ? 4 : 0;
  endfunction

  function automatic int o_turn(input int k);
    case (k)
      0:       return int'(turn_a);
      1:       return int'(turn_b);
      default: return int'(turn_c);
    endcase
  endfunction
  function automatic int o_col(input int k);
    case (k)
      0:       return int'(col_a);
      1:       return int'(col_b);
      default: return int'(col_c);
    endcase
  endfunction
  function automatic int o_mc(input int k);
    case (k)
      0:       return int'(mc_a);
      1:       return int'(mc_b);
      default: return int'(mc_c);
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int k,
                     input int obs, input int exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s dut%0d: observed %0d expected %0d",
                tag, k, obs, exp);
  endtask

  task automatic snap(input int k);
    b_rps[k] = n_rps[k];
    b_drp[k] = n_drp[k];
    b_chk[k] = n_chk[k];
    b_rej[k] = n_rej[k];
    b_snd[k] = n_snd[k];
  endtask

  task automatic upd_cf(input int k);
    logic [6:0] m;
    m = force_full[k];
    for (int c = 0; c < nc(k); c++)
      if (ht[k][c] >= nr(k)) m[c] = 1'b1;
    cf[k] = m;
  endtask

  task automatic m_reset(input int k);
    m_phase[k] = 0;
    m_turn[k] = 0;
    m_col[k] = stc(k);
    m_moves[k] = 0;
    for (int c = 0; c < 7; c++) ht[k][c] = 0;
    force_full[k] = '0;
    upd_cf(k);
  endtask

  task automatic check_state(input int k, input string tag);
    chk({tag, ".game_state"}, k, int'(gs[k]), m_phase[k]);
    chk({tag, ".turn"}, k, o_turn(k), m_turn[k]);
    chk({tag, ".col"}, k, o_col(k), m_col[k]);
    chk({tag, ".move_count"}, k, o_mc(k), m_moves[k]);
    chk({tag, ".sound_en"}, k, int'(snd[k]), 0);
  endtask

  task automatic new_game(input int k, input int hold);
    snap(k);
    bt[k] = 2'b11;
    tick(hold);
    bt[k] = 2'b00;
    tick(2);
    m_phase[k] = 1;
    m_turn[k] = 0;
    m_col[k] = stc(k);
    m_moves[k] = 0;
    for (int c = 0; c < 7; c++) ht[k][c] = 0;
    force_full[k] = '0;
    upd_cf(k);
    chk("new_game.reset_ps2", k, n_rps[k] - b_rps[k], 1);
    check_state(k, "new_game");
  endtask

  task automatic move(input int k, input int dir,
                      input int hold);
    int n;
    n = nc(k);
    snap(k);
    bt[k] = 2'(dir);
    tick(hold);
    bt[k] = 2'b00;
    tick(2);
    if (dir == 1)
      m_col[k] = (wrapf(k) != 0) ? (m_col[k] + 1) % n
               : ((m_col[k] < n - 1) ? m_col[k] + 1 : n - 1);
    else
      m_col[k] = (wrapf(k) != 0) ? (m_col[k] + n - 1) % n
               : ((m_col[k] > 0) ? m_col[k] - 1 : 0);
    chk("move.reset_ps2", k, n_rps[k] - b_rps[k], 1);
    chk("move.drop", k, n_drp[k] - b_drp[k], 0);
    check_state(k, "move");
  endtask

  task automatic drop(input int k, input int hold,
                      input bit w, input int d1,
                      input int d2);
    int wt;
    snap(k);
    if ($urandom_range(0, 3) == 0) begin
      dd[k] = 1'b1;
      dc[k] = 1'b1;
      wn[k] = 1'b1;
      tick(1);
      dd[k] = 1'b0;
      dc[k] = 1'b0;
      wn[k] = 1'b0;
    end
    bt[k] = 2'b11;
    tick(hold);
    bt[k] = 2'b00;
    tick(1);
    if (cf[k][m_col[k]]) begin
      chk("reject.rejected", k, int'(rej[k]), 1);
      chk("reject.drop_now", k, int'(drp[k]), 0);
      tick(1);
      chk("reject.one_cycle", k, int'(rej[k]), 0);
      chk("reject.count", k, n_rej[k] - b_rej[k], 1);
      chk("reject.drops", k, n_drp[k] - b_drp[k], 0);
      chk("reject.reset_ps2", k, n_rps[k] - b_rps[k], 1);
      check_state(k, "reject");
      return;
    end
    chk("drop.pulse", k, int'(drp[k]), 1);
    // winner must be ignored while the drop is pending
    if (d1 > 0) begin
      dc[k] = 1'b1;
      wn[k] = 1'b1;
      tick(1);
      dc[k] = 1'b0;
      wn[k] = 1'b0;
      tick(d1 - 1);
    end
    dd[k] = 1'b1;
    tick(1);
    dd[k] = 1'b0;
    m_moves[k]++;
    ht[k][m_col[k]]++;
    chk("drop.sound_on", k, int'(snd[k]), 1);
    wt = 0;
    while (chkp[k] !== 1'b1 && wt < scyc(k) + 4) begin
      tick(1);
      wt++;
    end
    chk("drop.check_pulse", k, int'(chkp[k]), 1);
    chk("drop.sound_len", k, wt, scyc(k));
    tick(d2);
    dc[k] = 1'b1;
    wn[k] = w;
    tick(1);
    dc[k] = 1'b0;
    wn[k] = 1'b0;
    tick(1);
    if (w)
      m_phase[k] = 2;
    else if (m_moves[k] == nc(k) * nr(k))
      m_phase[k] = 3;
    else
      m_turn[k] = (m_turn[k] + 1) % np(k);
    upd_cf(k);
    chk("drop.drop_count", k, n_drp[k] - b_drp[k], 1);
    chk("drop.check_count", k, n_chk[k] - b_chk[k], 1);
    chk("drop.sound_cycles", k, n_snd[k] - b_snd[k],
        scyc(k));
    chk("drop.rejects", k, n_rej[k] - b_rej[k], 0);
    chk("drop.reset_ps2", k, n_rps[k] - b_rps[k], 1);
    check_state(k, "drop");
  endtask

  initial begin
    int base;
    clk = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      bt[k] = 2'b00;
      dd[k] = 1'b0;
      dc[k] = 1'b0;
      wn[k] = 1'b0;
      m_reset(k);
    end
    tick(3);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    tick(1);
    for (int k = 0; k < 3; k++) begin
      check_state(k, "reset");
      chk("reset.reset_ps2", k, int'(rps[k]), 0);
      chk("reset.drop", k, int'(drp[k]), 0);
      chk("reset.check", k, int'(chkp[k]), 0);
      chk("reset.rejected", k, int'(rej[k]), 0);
    end

    // cursor keys do nothing before a game starts
    bt[1] = 2'b01;
    tick(2);
    bt[1] = 2'b00;
    tick(2);
    check_state(1, "idle_keys");

    // start plus three right steps
    base = n_rps[0];
    new_game(0, 2);
    move(0, 1, 1);
    move(0, 1, 2);
    move(0, 1, 3);
    chk("start.col", 0, o_col(0), 3);
    chk("start.ps2_total", 0, n_rps[0] - base, 4);
    chk("start.turn", 0, o_turn(0), 0);
    chk("start.state", 0, int'(gs[0]), 1);

    // wrap at both edges
    repeat (3) move(0, 2, 1);
    move(0, 2, 2);
    chk("wrap_left", 0, o_col(0), 6);
    move(0, 1, 1);
    chk("wrap_right", 0, o_col(0), 0);

    // saturating cursor, long hold gives one step
    new_game(1, 1);
    repeat (5) move(1, 2, 1);
    chk("sat_left", 1, o_col(1), 0);
    move(1, 1, 100);
    chk("hold_100", 1, o_col(1), 1);
    repeat (6) move(1, 1, 2);
    chk("sat_right", 1, o_col(1), 6);

    // full column rejected, neighbour accepted
    force_full[0] = 7'b0001000;
    upd_cf(0);
    repeat (3) move(0, 1, 1);
    drop(0, 2, 1'b0, 1, 1);
    chk("reject.turn", 0, o_turn(0), 0);
    move(0, 2, 1);
    drop(0, 1, 1'b0, 0, 0);
    chk("turn_1", 0, o_turn(0), 1);
    drop(0, 1, 1'b0, 2, 2);
    chk("turn_2", 0, o_turn(0), 2);
    drop(0, 3, 1'b0, 3, 0);
    chk("turn_0", 0, o_turn(0), 0);
    force_full[0] = '0;
    upd_cf(0);

    // 2x2 board: draw, then win on the last cell
    new_game(2, 1);
    drop(2, 1, 1'b0, 0, 0);
    drop(2, 2, 1'b0, 1, 1);
    move(2, 1, 1);
    drop(2, 1, 1'b0, 2, 0);
    drop(2, 1, 1'b0, 0, 2);
    chk("draw.state", 2, int'(gs[2]), 3);
    chk("draw.moves", 2, o_mc(2), 4);
    new_game(2, 2);
    drop(2, 1, 1'b0, 1, 0);
    drop(2, 1, 1'b0, 0, 0);
    move(2, 1, 2);
    drop(2, 1, 1'b0, 0, 1);
    drop(2, 1, 1'b1, 1, 1);
    chk("win.state", 2, int'(gs[2]), 2);
    chk("win.moves", 2, o_mc(2), 4);
    chk("win.turn", 2, o_turn(2), 1);

    // reset in the middle of the drop sound
    bt[0] = 2'b11;
    tick(1);
    bt[0] = 2'b00;
    tick(1);
    dd[0] = 1'b1;
    tick(1);
    dd[0] = 1'b0;
    tick(3);
    chk("rst_sound.before", 0, int'(snd[0]), 1);
    rst[0] = 1'b1;
    tick(1);
    rst[0] = 1'b0;
    m_reset(0);
    check_state(0, "rst_sound");
    chk("rst_sound.check", 0, int'(chkp[0]), 0);
    tick(2);
    check_state(0, "rst_sound.idle");
    new_game(0, 1);

    // random play
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 60; i++) begin
        if (m_phase[k] != 1)
          new_game(k, int'($urandom_range(1, 3)));
        else if ($urandom_range(0, 1) == 1)
          move(k, int'($urandom_range(1, 2)),
               int'($urandom_range(1, 4)));
        else
          drop(k, int'($urandom_range(1, 3)),
               ($urandom_range(0, 11) == 0),
               int'($urandom_range(0, 3)),
               int'($urandom_range(0, 2)));
      end
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
